mul_hilo_ctrl: RTL

Sequencer between the CPU execute stage and the shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH, fixed 2*WIDTH cycles per product). It accepts MULT/MULTU/MTHI/MTLO commands and converts signed operands to magnitudes. It drives the multiplier start and operand lines, counts the run, applies the sign fix to the product and writes the HI/LO registers. It stalls the pipeline on HI/LO access while a product is pending.

---
 rtl/mul_hilo_pkg.sv | 23 ++
 rtl/mul_sign_fix.sv | 13 +
 rtl/mul_hilo_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mul_hilo_pkg.sv
// Shared encodings for the HI/LO multiply sequencer: command opcodes, FSM states
// and the run-counter width helper.
package mul_hilo_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'd0,
      OP_MULT  = 2'd1,
      OP_MTHI  = 2'd2,
      OP_MTLO  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      WB
   } state_e;

   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and the
// product sign fix.
module mul_sign_fix #(
   parameter int unsigned W = 16
) (
   input  logic         i_neg,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO sequencer for a fixed-latency shift-add multiplier.
// Define MUL_SIGNED_EN to build signed MULT; otherwise MULT behaves as MULTU.
module mul_hilo_ctrl
   import mul_hilo_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned MUL_CYCLES = 2 * WIDTH
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [WIDTH-1:0]     OpA,
   input  logic [WIDTH-1:0]     OpB,
   output logic                 Ready,
   input  logic                 ReadReq,
   output logic                 Stall,
   output logic [WIDTH-1:0]     Hi,
   output logic [WIDTH-1:0]     Lo,
   output logic                 MulSy,
   output logic [WIDTH-1:0]     MulA,
   output logic [WIDTH-1:0]     MulB,
   output logic [WIDTH-1:0]     MulAReg,
   input  logic [2*WIDTH-1:0]   MulProduct
);

   localparam int unsigned CNT_W = cnt_width(MUL_CYCLES);

   state_e               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_neg;
   logic                 r_ready;
   logic                 r_mul_sy;
   logic [WIDTH-1:0]     r_mag_a;
   logic [WIDTH-1:0]     r_mag_b;
   logic [WIDTH-1:0]     r_mul_a_reg;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   op_e                  w_op;
   logic                 w_signed;
   logic                 w_neg_a;
   logic                 w_neg_b;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_prod;

   assign w_op = op_e'(Op);

`ifdef MUL_SIGNED_EN
   assign w_signed = (w_op == OP_MULT);
`else
   assign w_signed = 1'b0;
`endif

   assign w_neg_a = w_signed & OpA[WIDTH-1];
   assign w_neg_b = w_signed & OpB[WIDTH-1];

   mul_sign_fix #(.W(WIDTH)) u_fix_a (
      .i_neg (w_neg_a),
      .i_val (OpA),
      .o_val (w_mag_a)
   );

   mul_sign_fix #(.W(WIDTH)) u_fix_b (
      .i_neg (w_neg_b),
      .i_val (OpB),
      .o_val (w_mag_b)
   );

   mul_sign_fix #(.W(2 * WIDTH)) u_fix_p (
      .i_neg (r_neg),
      .i_val (MulProduct),
      .o_val (w_prod)
   );

   // MulSy is registered: raised on the accept edge so it is high for exactly the LOAD cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_neg       <= 1'b0;
         r_ready     <= 1'b1;
         r_mul_sy    <= 1'b0;
         r_mag_a     <= '0;
         r_mag_b     <= '0;
         r_mul_a_reg <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Start) begin
                  case (w_op)
                     OP_MULTU, OP_MULT: begin
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_neg    <= w_neg_a ^ w_neg_b;
                        r_mul_sy <= 1'b1;
                        r_ready  <= 1'b0;
                        r_state  <= LOAD;
                     end
                     OP_MTHI: r_hi <= OpA;
                     default: r_lo <= OpA;
                  endcase
               end
            end
            LOAD: begin
               r_mul_sy    <= 1'b0;
               r_mul_a_reg <= r_mag_a;
               r_cnt       <= CNT_W'(MUL_CYCLES - 1);
               r_state     <= RUN;
            end
            RUN: begin
               if (r_cnt == '0) r_state <= WB;
               else             r_cnt   <= r_cnt - CNT_W'(1);
            end
            WB: begin
               r_hi    <= w_prod[2*WIDTH-1:WIDTH];
               r_lo    <= w_prod[WIDTH-1:0];
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Ready   = r_ready;
   assign Stall   = ReadReq & ~r_ready;
   assign Hi      = r_hi;
   assign Lo      = r_lo;
   assign MulSy   = r_mul_sy;
   assign MulA    = r_mag_a;
   assign MulB    = r_mag_b;
   assign MulAReg = r_mul_a_reg;

endmodule
